player_ctrl: RTL and testbench

//   Sequences the player sprite that draw_player renders. Owns player_x/player_y/player_state,

---
 rtl/game_pkg.sv | 39 +++
 rtl/tick_gen.sv | 37 +++
 rtl/player_ctrl.sv | 165 ++++++++++++++++
 tb/tb_player_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: encodings shared by the game controllers.
//   TITLE/STAGE1..3 : game-state codes driven by the game FSM (4 bits)
//   dir_t           : sprite facing direction, as packed into a player_state nibble
//   pstate_t        : player FSM states
//   SPRITE_W        : sprite width in half-res pixels
//   is_stage()      : true for STAGE1..3
//   stage_idx()     : nibble slot (0..2) owned by a stage
package game_pkg;

    localparam logic [3:0] TITLE  = 4'd0;
    localparam logic [3:0] STAGE1 = 4'd2;
    localparam logic [3:0] STAGE2 = 4'd4;
    localparam logic [3:0] STAGE3 = 4'd6;

    localparam int SPRITE_W = 10;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_WALK = 2'd1,
        P_DEAD = 2'd2
    } pstate_t;

    function automatic logic is_stage(input logic [3:0] s);
        return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
    endfunction

    // STAGE1/2/3 = 2/4/6, so bits [2:1] are 1/2/3.
    function automatic logic [1:0] stage_idx(input logic [3:0] s);
        return s[2:1] - 2'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider producing a one-cycle pulse every DIV cycles.
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   tick  out 1  registered pulse, high in the cycle the counter holds DIV-1
module tick_gen #(
    parameter int DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;

    // NOTE: combinational blocks assign every output before any branch so no latch is inferred.
    always_comb begin
        cnt_next = cnt + W'(1);
        if (cnt == LAST) cnt_next = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // The pulse is registered from cnt_next so it lines up with the cycle cnt reads LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == LAST);
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: player sprite position, walk animation and death/respawn sequencing.
//   clk, rst_n           clock, asynchronous active-low reset
//   state[3:0]           game state (TITLE/STAGE1..3)
//   key_up/down/left/right  held direction keys
//   hit                  one-cycle collision pulse
//   player_x/y[26:0]     sprite position, zero-extended 9-bit values
//   player_state[11:0]   {S3,S2,S1} nibbles, each {dir[1:0],frame[1:0]}
//   dead                 high while dying
//   move_tick            one-cycle pulse every MOVE_DIV cycles
module player_ctrl
    import game_pkg::*;
#(
    parameter int MOVE_DIV   = 1_000_000,
    parameter int ANIM_DIV   = 8,
    parameter int DEAD_TICKS = 100,
    parameter int X_MAX      = 320 - SPRITE_W,
    parameter int Y_MAX      = 230,
    parameter int SPAWN_X    = 105,
    parameter int SPAWN_Y    = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  state,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        hit,
    output logic [26:0] player_x,
    output logic [26:0] player_y,
    output logic [11:0] player_state,
    output logic        dead,
    output logic        move_tick
);

    localparam int AW = $clog2(ANIM_DIV + 1);
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam logic [AW-1:0] A_LAST = AW'(ANIM_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEAD_TICKS - 1);
    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [8:0] Y_LIM = 9'(Y_MAX);
    localparam logic [8:0] X_SPN = 9'(SPAWN_X);
    localparam logic [8:0] Y_SPN = 9'(SPAWN_Y);

    logic [8:0]       x, y, x_step, y_step;
    logic [2:0][3:0]  ps;
    pstate_t          pstate;
    logic [AW-1:0]    anim_cnt;
    logic [DW-1:0]    dead_cnt;
    logic [3:0]       prev_state;
    dir_t             step_dir;
    logic             any_key, in_stage, stage_entry, anim_wrap;
    logic [1:0]       idx, title_frame;

    tick_gen #(.DIV(MOVE_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (move_tick)
    );

    assign player_x     = {18'd0, x};
    assign player_y     = {18'd0, y};
    assign player_state = ps;

    assign any_key     = key_up | key_down | key_left | key_right;
    assign in_stage    = is_stage(state);
    assign stage_entry = in_stage && (state != prev_state);
    assign idx         = stage_idx(state);
    assign anim_wrap   = move_tick && (anim_cnt == A_LAST);
    // TITLE drives all three nibbles from S1's frame.
    assign title_frame = anim_wrap ? ps[0][1:0] + 2'd1 : ps[0][1:0];

    // Single-key pick (up > down > left > right) with bound check before the step.
    always_comb begin
        step_dir = DIR_RIGHT;
        x_step   = x;
        y_step   = y;
        if (key_up) begin
            step_dir = DIR_UP;
            if (y != 9'd0) y_step = y - 9'd1;
        end else if (key_down) begin
            step_dir = DIR_DOWN;
            if (y < Y_LIM) y_step = y + 9'd1;
        end else if (key_left) begin
            step_dir = DIR_LEFT;
            if (x != 9'd0) x_step = x - 9'd1;
        end else begin
            if (x < X_LIM) x_step = x + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= X_SPN;
            y          <= Y_SPN;
            ps         <= '0;
            pstate     <= P_IDLE;
            anim_cnt   <= '0;
            dead_cnt   <= '0;
            dead       <= 1'b0;
            prev_state <= TITLE;
        end else begin
            prev_state <= state;
            if (stage_entry) begin
                // Entering a stage always restarts the player, even mid-death.
                x        <= X_SPN;
                y        <= Y_SPN;
                ps[idx]  <= '0;
                pstate   <= P_IDLE;
                anim_cnt <= '0;
                dead_cnt <= '0;
                dead     <= 1'b0;
            end else if (state == TITLE) begin
                ps <= {3{DIR_DOWN, title_frame}};
                if (move_tick) anim_cnt <= anim_wrap ? '0 : anim_cnt + AW'(1);
            end else if (in_stage) begin
                unique case (pstate)
                    P_IDLE: begin
                        if (hit) begin
                            pstate   <= P_DEAD;
                            dead     <= 1'b1;
                            dead_cnt <= '0;
                        end else if (any_key) begin
                            pstate <= P_WALK;
                        end
                    end
                    P_WALK: begin
                        if (hit) begin
                            pstate   <= P_DEAD;
                            dead     <= 1'b1;
                            dead_cnt <= '0;
                        end else if (!any_key) begin
                            pstate       <= P_IDLE;
                            ps[idx][1:0] <= 2'd0;
                            anim_cnt     <= '0;
                        end else if (move_tick) begin
                            ps[idx][3:2] <= step_dir;
                            x            <= x_step;
                            y            <= y_step;
                            anim_cnt     <= anim_wrap ? '0 : anim_cnt + AW'(1);
                            if (anim_wrap) ps[idx][1:0] <= ps[idx][1:0] + 2'd1;
                        end
                    end
                    P_DEAD: begin
                        if (move_tick) begin
                            if (dead_cnt == D_LAST) begin
                                x        <= X_SPN;
                                y        <= Y_SPN;
                                ps[idx]  <= {DIR_DOWN, 2'd0};
                                pstate   <= P_IDLE;
                                anim_cnt <= '0;
                                dead_cnt <= '0;
                                dead     <= 1'b0;
                            end else begin
                                dead_cnt <= dead_cnt + DW'(1);
                            end
                        end
                    end
                    default: pstate <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;

    localparam int MOVE_DIV   = 4;
    localparam int ANIM_DIV   = 2;
    localparam int DEAD_TICKS = 3;
    localparam int X_MAX      = 310;
    localparam int Y_MAX      = 230;
    localparam int SPAWN_X    = 105;
    localparam int SPAWN_Y    = 125;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  state = 4'd0;
    logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic        hit = 1'b0;
    logic [26:0] player_x, player_y;
    logic [11:0] player_state;
    logic        dead, move_tick;

    int errors = 0;
    int checks = 0;

    player_ctrl #(
        .MOVE_DIV(MOVE_DIV), .ANIM_DIV(ANIM_DIV), .DEAD_TICKS(DEAD_TICKS),
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .hit(hit), .player_x(player_x), .player_y(player_y),
        .player_state(player_state), .dead(dead), .move_tick(move_tick)
    );

    always #5 clk = ~clk;

    // Reference model: rules applied once per clock edge on plain integers.
    int   m_x, m_y, m_anim, m_dcnt, m_edges;
    int   m_frame[3];
    int   m_dir[3];
    bit   m_walk, m_dead;
    logic [3:0] m_prev;

    task automatic model_reset();
        m_x = SPAWN_X; m_y = SPAWN_Y; m_anim = 0; m_dcnt = 0; m_edges = 0;
        for (int k = 0; k < 3; k++) begin m_frame[k] = 0; m_dir[k] = 0; end
        m_walk = 0; m_dead = 0; m_prev = 4'd0;
    endtask

    function automatic bit model_tick();
        return (m_edges % MOVE_DIV) == MOVE_DIV - 1;
    endfunction

    function automatic logic [11:0] model_ps();
        logic [11:0] r;
        for (int k = 0; k < 3; k++) r[4*k +: 4] = {2'(m_dir[k]), 2'(m_frame[k])};
        return r;
    endfunction

    task automatic model_step();
        bit tk  = model_tick();
        bit any = key_up | key_down | key_left | key_right;
        bit stg = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
        int a   = int'(state) / 2 - 1;
        if (stg && state != m_prev) begin
            m_x = SPAWN_X; m_y = SPAWN_Y; m_frame[a] = 0; m_dir[a] = 0;
            m_walk = 0; m_dead = 0; m_anim = 0; m_dcnt = 0;
        end else if (state == 4'd0) begin
            if (tk) begin
                m_anim++;
                if (m_anim == ANIM_DIV) begin m_anim = 0; m_frame[0] = (m_frame[0] + 1) % 4; end
            end
            for (int k = 0; k < 3; k++) begin m_dir[k] = 0; m_frame[k] = m_frame[0]; end
        end else if (stg) begin
            if (m_dead) begin
                if (tk) begin
                    m_dcnt++;
                    if (m_dcnt == DEAD_TICKS) begin
                        m_x = SPAWN_X; m_y = SPAWN_Y; m_frame[a] = 0; m_dir[a] = 0;
                        m_dcnt = 0; m_anim = 0; m_dead = 0; m_walk = 0;
                    end
                end
            end else if (hit) begin
                m_dead = 1; m_dcnt = 0;
            end else if (!m_walk) begin
                if (any) m_walk = 1;
            end else if (!any) begin
                m_walk = 0; m_frame[a] = 0; m_anim = 0;
            end else if (tk) begin
                if (key_up)         begin m_dir[a] = 1; if (m_y > 0) m_y--; end
                else if (key_down)  begin m_dir[a] = 0; if (m_y < Y_MAX) m_y++; end
                else if (key_left)  begin m_dir[a] = 2; if (m_x > 0) m_x--; end
                else                begin m_dir[a] = 3; if (m_x < X_MAX) m_x++; end
                m_anim++;
                if (m_anim == ANIM_DIV) begin m_anim = 0; m_frame[a] = (m_frame[a] + 1) % 4; end
            end
        end
        m_prev = state;
        m_edges++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Stops on a negedge where move_tick is high, without consuming that tick.
    task automatic sync_tick();
        int n = 0;
        while (move_tick !== 1'b1 && n < 2 * MOVE_DIV) begin cycle(); n++; end
        checks++;
        if (move_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout: move_tick=%b after %0d cycles, want 1", move_tick, n);
        end
    endtask

    task automatic wait_tick();
        sync_tick();
        cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; state = 4'd0; hit = 1'b0;
        {key_up, key_down, key_left, key_right} = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({player_x, player_y, player_state, dead, move_tick} !==
            {27'd105, 27'd125, 12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: x=%0d y=%0d ps=%h dead=%b tick=%b, want 105 125 000 0 0",
                     player_x, player_y, player_state, dead, move_tick);
        end
    endtask

    task automatic test_walk_right();
        state = 4'd2;
        cycle();
        key_right = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            logic [11:0] exp_ps;
            wait_tick();
            exp_ps = {8'h00, 2'd3, 2'((t / 2) % 4)};
            checks++;
            if (player_x !== 27'(105 + t) || player_y !== 27'd125 || player_state !== exp_ps) begin
                errors++;
                $display("FAIL walk_right t=%0d: x=%0d y=%0d ps=%h, want %0d 125 %h",
                         t, player_x, player_y, player_state, 105 + t, exp_ps);
            end
        end
    endtask

    task automatic test_bounds();
        int n = 0;
        while (player_x !== 27'd310 && n < 300) begin wait_tick(); n++; end
        checks++;
        if (player_x !== 27'd310) begin
            errors++;
            $display("FAIL reach_xmax: x=%0d, want 310", player_x);
        end
        for (int t = 1; t <= 3; t++) begin
            wait_tick();
            checks++;
            if (player_x !== 27'd310 || player_state[3:2] !== 2'd3) begin
                errors++;
                $display("FAIL clamp_xmax t=%0d: x=%0d dir=%0d, want 310 3",
                         t, player_x, player_state[3:2]);
            end
        end
        key_right = 1'b0; key_up = 1'b1; key_left = 1'b1;
        for (int t = 1; t <= 2; t++) begin
            wait_tick();
            checks++;
            if (player_y !== 27'(125 - t) || player_x !== 27'd310 || player_state[3:2] !== 2'd1) begin
                errors++;
                $display("FAIL up_over_left t=%0d: x=%0d y=%0d dir=%0d, want 310 %0d 1",
                         t, player_x, player_y, player_state[3:2], 125 - t);
            end
        end
    endtask

    task automatic test_hit_on_tick();
        sync_tick();
        hit = 1'b1;
        cycle();
        hit = 1'b0;
        checks++;
        if (dead !== 1'b1 || player_x !== 27'd310 || player_y !== 27'd123) begin
            errors++;
            $display("FAIL hit_on_tick: dead=%b x=%0d y=%0d, want 1 310 123", dead, player_x, player_y);
        end
        for (int t = 1; t <= 3; t++) begin
            wait_tick();
            checks++;
            if (t < 3) begin
                if (dead !== 1'b1 || player_x !== 27'd310 || player_y !== 27'd123) begin
                    errors++;
                    $display("FAIL dead_hold t=%0d: dead=%b x=%0d y=%0d, want 1 310 123",
                             t, dead, player_x, player_y);
                end
            end else if (dead !== 1'b0 || player_x !== 27'd105 || player_y !== 27'd125 ||
                         player_state !== 12'h000) begin
                errors++;
                $display("FAIL respawn: dead=%b x=%0d y=%0d ps=%h, want 0 105 125 000",
                         dead, player_x, player_y, player_state);
            end
        end
        key_up = 1'b0; key_left = 1'b0;
        cycle();
    endtask

    task automatic test_stage_switch_dead();
        key_right = 1'b1;
        cycle();
        wait_tick();
        wait_tick();
        checks++;
        if (player_x !== 27'd107 || player_state !== 12'h00d) begin
            errors++;
            $display("FAIL pre_switch: x=%0d ps=%h, want 107 00d", player_x, player_state);
        end
        hit = 1'b1;
        cycle();
        hit = 1'b0;
        checks++;
        if (dead !== 1'b1) begin
            errors++;
            $display("FAIL hit_walk: dead=%b, want 1", dead);
        end
        state = 4'd4;
        cycle();
        checks++;
        if (dead !== 1'b0 || player_x !== 27'd105 || player_y !== 27'd125 || player_state !== 12'h00d) begin
            errors++;
            $display("FAIL stage_switch: dead=%b x=%0d y=%0d ps=%h, want 0 105 125 00d",
                     dead, player_x, player_y, player_state);
        end
        key_right = 1'b0;
        cycle();
    endtask

    task automatic test_title();
        do_reset();
        state = 4'd2;
        cycle();
        key_right = 1'b1;
        cycle();
        wait_tick();
        key_right = 1'b0;
        cycle();
        state = 4'd0;
        for (int t = 1; t <= 6; t++) begin
            logic [3:0] nib;
            wait_tick();
            nib = {2'd0, 2'((t / 2) % 4)};
            checks++;
            if (player_state !== {3{nib}} || player_x !== 27'd106 || player_y !== 27'd125) begin
                errors++;
                $display("FAIL title t=%0d: ps=%h x=%0d y=%0d, want %h 106 125",
                         t, player_state, player_x, player_y, {3{nib}});
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        state = 4'd2;
        cycle();
        key_right = 1'b1;
        cycle();
        wait_tick();
        wait_tick();
        checks++;
        if (player_x !== 27'd107) begin
            errors++;
            $display("FAIL pre_reset: x=%0d, want 107", player_x);
        end
        sync_tick();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({player_x, player_y, player_state, dead, move_tick} !==
            {27'd105, 27'd125, 12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: x=%0d y=%0d ps=%h dead=%b tick=%b, want 105 125 000 0 0",
                     player_x, player_y, player_state, dead, move_tick);
        end
        key_right = 1'b0; state = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(59, 0) == 0) begin
                case ($urandom_range(5, 0))
                    0: state = 4'd0;
                    1: state = 4'd2;
                    2: state = 4'd4;
                    3: state = 4'd6;
                    4: state = 4'd1;
                    default: state = 4'd9;
                endcase
            end
            if ($urandom_range(7, 0) == 0)
                {key_up, key_down, key_left, key_right} = 4'($urandom_range(15, 0));
            hit = ($urandom_range(79, 0) == 0);
            cycle();
            checks++;
            if ({player_x, player_y, player_state, dead, move_tick} !==
                {27'(m_x), 27'(m_y), model_ps(), m_dead, model_tick()}) begin
                errors++;
                if (shown < 10)
                    $display("FAIL random cyc=%0d: x=%0d y=%0d ps=%h dead=%b tick=%b, want %0d %0d %h %b %b",
                             i, player_x, player_y, player_state, dead, move_tick,
                             m_x, m_y, model_ps(), m_dead, model_tick());
                shown++;
            end
        end
        hit = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_walk_right();
        test_bounds();
        test_hit_on_tick();
        test_stage_switch_dead();
        test_title();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
